// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with valid/ready output and a main+skid buffer
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_control,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal
);
  localparam int EW = WIDTH + 3;
  logic [WIDTH-1:0] sum, diff, res;
  logic             slt, legal, ovf, accept, main_take;
  logic [EW-1:0]    new_e, main_q, main_d, skid_q, skid_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  always_comb begin
    sum    = in_a + in_b;
    diff   = in_a - in_b;
    slt    = $signed(in_a) < $signed(in_b);
    legal  = in_alu_control inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    res    = in_alu_control == 4'b0000 ? in_a & in_b :
             in_alu_control == 4'b0001 ? in_a | in_b :
             in_alu_control == 4'b0010 ? sum :
             in_alu_control == 4'b0110 ? diff :
             in_alu_control == 4'b0111 ? {{(WIDTH-1){1'b0}}, slt} : '0;
    ovf    = in_alu_control == 4'b0010 ? (in_a[WIDTH-1] == in_b[WIDTH-1] && sum[WIDTH-1] != in_a[WIDTH-1]) :
             in_alu_control == 4'b0110 ? (in_a[WIDTH-1] != in_b[WIDTH-1] && diff[WIDTH-1] != in_a[WIDTH-1]) : 1'b0;
    new_e  = {!legal, ovf, res == '0, res};
  end
  always_comb begin
    accept     = in_valid && in_ready_q;
    main_take  = !main_v_q || out_ready;
    main_v_d   = main_take ? (skid_v_q || accept) : main_v_q;
    main_d     = main_take ? (skid_v_q ? skid_q : accept ? new_e : main_q) : main_q;
    skid_v_d   = main_take ? 1'b0 : (skid_v_q || accept);
    skid_d     = (!main_take && accept) ? new_e : skid_q;
    in_ready_d = !skid_v_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready    = in_ready_q;
  assign out_valid   = main_v_q;
  assign out_result  = main_q[WIDTH-1:0];
  assign out_zero    = main_q[WIDTH];
  assign out_ovf     = main_q[WIDTH+1];
  assign out_illegal = main_q[WIDTH+2];
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_zero, out_ovf, out_illegal;
  logic [3:0]  in_alu_control;
  logic [31:0] in_a, in_b, out_result;
  int checks = 0;
  int failures = 0;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_control(in_alu_control), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid       = 1'b0;
    in_alu_control = 'x;
    in_a           = 'x;
    in_b           = 'x;
  endtask

  task automatic offer(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid       = 1'b1;
    in_alu_control = c;
    in_a           = a;
    in_b           = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    offer(4'b0010, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: out_valid=%b in_ready=%b want 0 0", i, out_valid, in_ready);
      end
    end
    checks++;
    if (out_result !== 32'd0 || out_zero !== 1'b0 || out_ovf !== 1'b0 || out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs: result=%h zero=%b ovf=%b ill=%b want 0 0 0 0", out_result, out_zero, out_ovf, out_illegal);
    end
    idle();
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_op(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic eo, input logic ei);
    out_ready = 1'b1;
    offer(c, a, b);
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_result !== er || out_zero !== ez || out_ovf !== eo || out_illegal !== ei) begin
      failures++;
      $display("FAIL %s: valid=%b result=%h zero=%b ovf=%b ill=%b want 1 %h %b %b %b",
               name, out_valid, out_result, out_zero, out_ovf, out_illegal, er, ez, eo, ei);
    end
  endtask

  task automatic test_alu_ops();
    test_op("add", 4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1'b0);
    test_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    test_op("and", 4'b0000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1'b0);
    test_op("or", 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    test_op("slt_true", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    test_op("slt_false", 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    test_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    test_op("sub_ovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    test_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    test_op("illegal", 4'b0101, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(4'b0010, 32'd1, 32'd2);
    step();
    offer(4'b0110, 32'd10, 32'd3);
    step();
    offer(4'b1111, 32'd3, 32'd4);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd3) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b valid=%b result=%h want 0 1 00000003", in_ready, out_valid, out_result);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd3 || out_ovf !== 1'b0 || out_illegal !== 1'b0) begin
        failures++;
        $display("FAIL bp_stable[%0d]: in_ready=%b valid=%b result=%h want 0 1 00000003", i, in_ready, out_valid, out_result);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd7 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: valid=%b result=%h in_ready=%b want 1 00000007 1", out_valid, out_result, in_ready);
    end
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 || out_illegal !== 1'b1) begin
      failures++;
      $display("FAIL bp_third: valid=%b result=%h zero=%b ill=%b want 1 00000000 1 1", out_valid, out_result, out_zero, out_illegal);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_nodup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    offer(4'b0010, 32'd100, 32'd1);
    step();
    offer(4'b0010, 32'd200, 32'd1);
    step();
    idle();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rf_full: in_ready=%b valid=%b want 0 1", in_ready, out_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0) begin
      failures++;
      $display("FAIL rf_cleared: valid=%b result=%h want 0 00000000", out_valid, out_result);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_release: in_ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    test_op("rf_new_op", 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_alone: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
